// File: rtl/smart_tl_ctl_nphase.sv
// Smart traffic light controller for an N-phase intersection.
// Main road on phase 0, secondaries served round-robin, plus night flashing.
module smart_tl_ctl_nphase #(
    parameter int N_PH        = 4,
    parameter int CNT_W       = 8,
    parameter int THRESHOLD   = 45,
    parameter int MIN_GREEN   = 30,
    parameter int EXT_GREEN   = 30,
    parameter int SEC_GREEN   = 10,
    parameter int YELLOW_TIME = 3,
    parameter int FLASH_HALF  = 4,
    parameter int TMR_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PH*CNT_W-1:0]     cars,
    input  logic                      flash_req,
    output logic [2*N_PH-1:0]         ctl,
    output logic [$clog2(N_PH)-1:0]   active_phase,
    output logic                      flashing
);

    localparam int PW = $clog2(N_PH);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_MAIN       = 4'd1;
    localparam logic [3:0] S_EXT        = 4'd2;
    localparam logic [3:0] S_TO_SEC     = 4'd3;
    localparam logic [3:0] S_SEC        = 4'd4;
    localparam logic [3:0] S_TO_MAIN    = 4'd5;
    localparam logic [3:0] S_TO_FLASH   = 4'd6;
    localparam logic [3:0] S_FLASH      = 4'd7;
    localparam logic [3:0] S_FLASH_EXIT = 4'd8;

    localparam logic [1:0] L_RED = 2'b01;
    localparam logic [1:0] L_YEL = 2'b10;
    localparam logic [1:0] L_GRN = 2'b11;

    localparam logic [2*N_PH-1:0] ALL_RED = {N_PH{L_RED}};

    localparam logic [TMR_W-1:0] T_MIN = TMR_W'(MIN_GREEN - 1);
    localparam logic [TMR_W-1:0] T_EXT = TMR_W'(EXT_GREEN - 1);
    localparam logic [TMR_W-1:0] T_SEC = TMR_W'(SEC_GREEN - 1);
    localparam logic [TMR_W-1:0] T_Y   = TMR_W'(YELLOW_TIME - 1);
    localparam logic [TMR_W-1:0] T_FH  = TMR_W'(FLASH_HALF - 1);

    logic [3:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [PW-1:0]    sel_q, sel_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic             half_q, half_d;

    logic [CNT_W-1:0] cnt [N_PH];
    logic             found;
    logic [PW-1:0]    scan_sel;
    logic             below;

    for (genvar p = 0; p < N_PH; p++) begin : g_cnt
        assign cnt[p] = cars[p*CNT_W +: CNT_W];
    end

    // Round-robin scan over 1..N_PH-1 starting just after the last served phase
    always_comb begin
        int idx;
        logic [PW-1:0] c;
        idx      = 0;
        c        = '0;
        found    = 1'b0;
        scan_sel = '0;
        for (int k = 1; k < N_PH; k++) begin
            idx = int'(rr_q) + k;
            if (idx > N_PH - 1) idx = idx - (N_PH - 1);
            c = PW'(idx);
            if (!found && cnt[c] != '0) begin
                found    = 1'b1;
                scan_sel = c;
            end
        end
        below = 32'(cnt[scan_sel]) < THRESHOLD;
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TMR_W'(1);
        sel_d   = sel_q;
        rr_d    = rr_q;
        half_d  = half_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_MAIN;
                tmr_d   = '0;
            end
            S_MAIN: begin
                if (flash_req) begin
                    state_d = S_TO_FLASH;
                    tmr_d   = '0;
                end else if (tmr_q == T_MIN) begin
                    tmr_d = '0;
                    if (found) begin
                        sel_d = scan_sel;
                        if (below) begin
                            state_d = S_EXT;
                        end else begin
                            state_d = S_TO_SEC;
                            rr_d    = scan_sel;
                        end
                    end
                end
            end
            S_EXT: begin
                if (flash_req) begin
                    state_d = S_TO_FLASH;
                    tmr_d   = '0;
                end else if (tmr_q == T_EXT) begin
                    state_d = S_TO_SEC;
                    tmr_d   = '0;
                    rr_d    = sel_q;
                end
            end
            S_TO_SEC: begin
                if (tmr_q == T_Y) begin
                    state_d = S_SEC;
                    tmr_d   = '0;
                end
            end
            S_SEC: begin
                if (tmr_q == T_SEC) begin
                    state_d = S_TO_MAIN;
                    tmr_d   = '0;
                end
            end
            S_TO_MAIN: begin
                if (tmr_q == T_Y) begin
                    state_d = S_MAIN;
                    tmr_d   = '0;
                end
            end
            S_TO_FLASH: begin
                if (tmr_q == T_Y) begin
                    state_d = S_FLASH;
                    tmr_d   = '0;
                    half_d  = 1'b0;
                end
            end
            S_FLASH: begin
                if (!flash_req) begin
                    state_d = S_FLASH_EXIT;
                    tmr_d   = '0;
                end else if (tmr_q == T_FH) begin
                    tmr_d  = '0;
                    half_d = ~half_q;
                end
            end
            S_FLASH_EXIT: begin
                if (tmr_q == T_Y) begin
                    state_d = S_MAIN;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            sel_q   <= '0;
            rr_q    <= PW'(N_PH - 1);
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            half_q  <= half_d;
        end
    end

    always_comb begin
        ctl          = '0;
        active_phase = '0;
        flashing     = 1'b0;
        case (state_q)
            S_MAIN, S_EXT: begin
                ctl      = ALL_RED;
                ctl[1:0] = L_GRN;
            end
            S_TO_SEC, S_TO_MAIN: begin
                ctl      = ALL_RED;
                ctl[1:0] = L_YEL;
                for (int p = 1; p < N_PH; p++)
                    if (PW'(p) == sel_q) ctl[2*p +: 2] = L_YEL;
                if (state_q == S_TO_SEC) active_phase = sel_q;
            end
            S_SEC: begin
                ctl = ALL_RED;
                for (int p = 1; p < N_PH; p++)
                    if (PW'(p) == sel_q) ctl[2*p +: 2] = L_GRN;
                active_phase = sel_q;
            end
            S_TO_FLASH: begin
                ctl      = ALL_RED;
                ctl[1:0] = L_YEL;
            end
            S_FLASH: begin
                flashing = 1'b1;
                if (!half_q) begin
                    ctl      = ALL_RED;
                    ctl[1:0] = L_YEL;
                end
            end
            S_FLASH_EXIT: begin
                ctl = ALL_RED;
            end
            default: begin
                ctl = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_smart_tl_ctl_nphase.sv
// Directed-vector bench for smart_tl_ctl_nphase (N_PH=4).
// Time index t counts clock edges after reset release, sampled on negedges.
module tb_smart_tl_ctl_nphase;

    localparam logic [1:0] D = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] G = 2'b11;

    logic        clk;
    logic        rst;
    logic [31:0] cars;
    logic        flash_req;
    logic [7:0]  ctl;
    logic [1:0]  active_phase;
    logic        flashing;

    int n_tests;
    int n_fail;
    int tc;
    logic [7:0] prev_ctl;

    smart_tl_ctl_nphase dut (
        .clk          (clk),
        .rst          (rst),
        .cars         (cars),
        .flash_req    (flash_req),
        .ctl          (ctl),
        .active_phase (active_phase),
        .flashing     (flashing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mk(
        input logic [1:0] p0, input logic [1:0] p1,
        input logic [1:0] p2, input logic [1:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)",
                     tag, got, exp, tc);
        end
    endtask

    task automatic adv_to(input int t);
        while (tc < t) begin
            @(negedge clk);
            tc++;
        end
    endtask

    task automatic expect_at(input string tag, input int t,
                             input logic [7:0] c,
                             input logic [1:0] a);
        adv_to(t);
        check({tag, "_ctl"}, ctl, c);
        check({tag, "_act"}, active_phase, a);
    endtask

    task automatic set_cars(input logic [7:0] c1,
                            input logic [7:0] c2,
                            input logic [7:0] c3);
        cars = {c3, c2, c1, 8'd0};
    endtask

    task automatic do_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tc  = 0;
    endtask

    // Lamp-sequence monitor: one green at most, no green straight to red
    always @(negedge clk) begin
        if (rst) begin
            int ng;
            logic bad;
            ng  = 0;
            bad = 1'b0;
            for (int p = 0; p < 4; p++) begin
                if (ctl[2*p +: 2] == G) ng++;
                if (prev_ctl[2*p +: 2] == G && ctl[2*p +: 2] == R)
                    bad = 1'b1;
            end
            check("one_green", 32'(ng > 1), 0);
            check("no_g_to_r", 32'(bad), 0);
        end
        prev_ctl = ctl;
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        tc        = 0;
        prev_ctl  = '0;
        rst       = 1'b0;
        flash_req = 1'b0;
        cars      = '0;

        // 1: reset state and idle main green with restarts
        repeat (2) @(negedge clk);
        check("rst_ctl", ctl, 0);
        check("rst_act", active_phase, 0);
        check("rst_flash", flashing, 0);
        do_reset();
        check("idle_ctl", ctl, 0);
        expect_at("s1_m0", 1, mk(G, R, R, R), 0);
        expect_at("s1_m29", 30, mk(G, R, R, R), 0);
        expect_at("s1_m30", 31, mk(G, R, R, R), 0);
        set_cars(0, 50, 0);
        expect_at("s1_rst_last", 60, mk(G, R, R, R), 0);
        expect_at("s1_rst_yel", 61, mk(Y, R, Y, R), 2);

        // 2: heavy traffic on phase 2
        set_cars(0, 50, 0);
        do_reset();
        expect_at("s2_mlast", 30, mk(G, R, R, R), 0);
        expect_at("s2_ys0", 31, mk(Y, R, Y, R), 2);
        expect_at("s2_ys2", 33, mk(Y, R, Y, R), 2);
        expect_at("s2_sg0", 34, mk(R, R, G, R), 2);
        expect_at("s2_sg9", 43, mk(R, R, G, R), 2);
        expect_at("s2_ym0", 44, mk(Y, R, Y, R), 0);
        expect_at("s2_ym2", 46, mk(Y, R, Y, R), 0);
        expect_at("s2_main", 47, mk(G, R, R, R), 0);

        // 3: threshold boundary 44 vs 45
        set_cars(44, 0, 0);
        do_reset();
        expect_at("s3_44_m30", 31, mk(G, R, R, R), 0);
        expect_at("s3_44_m59", 60, mk(G, R, R, R), 0);
        expect_at("s3_44_y", 61, mk(Y, Y, R, R), 1);
        set_cars(45, 0, 0);
        do_reset();
        expect_at("s3_45_m29", 30, mk(G, R, R, R), 0);
        expect_at("s3_45_y", 31, mk(Y, Y, R, R), 1);

        // 4: round-robin over three busy secondaries
        set_cars(50, 50, 50);
        do_reset();
        expect_at("s4_sec1", 34, mk(R, G, R, R), 1);
        expect_at("s4_sec2", 80, mk(R, R, G, R), 2);
        expect_at("s4_sec3", 126, mk(R, R, R, G), 3);
        expect_at("s4_sec1b", 172, mk(R, G, R, R), 1);

        // 5: night flashing entry and exit
        set_cars(0, 0, 0);
        do_reset();
        expect_at("s5_m10", 11, mk(G, R, R, R), 0);
        flash_req = 1'b1;
        expect_at("s5_tf0", 12, mk(Y, R, R, R), 0);
        expect_at("s5_tf2", 14, mk(Y, R, R, R), 0);
        check("s5_tf_flag", flashing, 0);
        expect_at("s5_lit0", 15, mk(Y, R, R, R), 0);
        check("s5_fl_flag", flashing, 1);
        expect_at("s5_lit3", 18, mk(Y, R, R, R), 0);
        expect_at("s5_dark0", 19, mk(D, D, D, D), 0);
        expect_at("s5_dark3", 22, mk(D, D, D, D), 0);
        expect_at("s5_lit4", 23, mk(Y, R, R, R), 0);
        expect_at("s5_dark4", 27, mk(D, D, D, D), 0);
        flash_req = 1'b0;
        expect_at("s5_exit0", 28, mk(R, R, R, R), 0);
        check("s5_exit_flag", flashing, 0);
        expect_at("s5_exit2", 30, mk(R, R, R, R), 0);
        expect_at("s5_main", 31, mk(G, R, R, R), 0);

        // 5b: flash request during secondary green is deferred
        set_cars(0, 50, 0);
        do_reset();
        expect_at("s5b_sg", 35, mk(R, R, G, R), 2);
        flash_req = 1'b1;
        expect_at("s5b_sg9", 43, mk(R, R, G, R), 2);
        expect_at("s5b_ym", 44, mk(Y, R, Y, R), 0);
        expect_at("s5b_main", 47, mk(G, R, R, R), 0);
        expect_at("s5b_tf", 48, mk(Y, R, R, R), 0);
        flash_req = 1'b0;

        // 6: asynchronous reset in secondary green
        set_cars(0, 50, 0);
        do_reset();
        expect_at("s6_sg", 36, mk(R, R, G, R), 2);
        rst = 1'b0;
        #1;
        check("s6_async_ctl", ctl, 0);
        check("s6_async_act", active_phase, 0);
        @(negedge clk);
        check("s6_hold_ctl", ctl, 0);
        set_cars(0, 0, 0);
        rst = 1'b1;
        tc  = 0;
        check("s6_idle", ctl, 0);
        expect_at("s6_m0", 1, mk(G, R, R, R), 0);
        expect_at("s6_m31", 32, mk(G, R, R, R), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
